// File: rtl/mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mult_arbiter
// Description : Round-robin arbiter / sequencer sharing one iterative 32x32
//               shift-add multiplier among NUM_REQ requesters. Latches the
//               winner's operands as magnitudes, strobes the multiplier, waits
//               for its done flag, sign-corrects the product and returns it
//               with a one-cycle acknowledge.
// Ports       : clk, rst            clock, synchronous active-high reset
//               req, req_signed     per-requester request / signedness
//               op_a, op_b          packed operands, requester i at [32i+:32]
//               ack, rsp_p          one-hot result strobe, shared product
//               busy                high in every state except IDLE
//               mul_a, mul_b        multiplier operand magnitudes
//               mul_ena, mul_rst    multiplier enable / load strobe
//               mul_p, mul_dne      multiplier product / done flag
// Revision    : 1.0 - initial release
// ============================================================================
module mult_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     req_signed,
  input  logic [32*NUM_REQ-1:0]  op_a,
  input  logic [32*NUM_REQ-1:0]  op_b,
  output logic [NUM_REQ-1:0]     ack,
  output logic [63:0]            rsp_p,
  output logic                   busy,
  output logic [31:0]            mul_a,
  output logic [31:0]            mul_b,
  output logic                   mul_ena,
  output logic                   mul_rst,
  input  logic [63:0]            mul_p,
  input  logic                   mul_dne
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_START = 2'd1;
  localparam logic [1:0] c_BUSY  = 2'd2;
  localparam logic [1:0] c_DONE  = 2'd3;

  // Last grant resets to the top index so requester 0 is searched first.
  localparam logic [IDX_W-1:0] c_LAST_RST = IDX_W'(NUM_REQ - 1);

  logic [1:0]       r_state;
  logic [1:0]       w_next;

  logic [IDX_W-1:0] r_grant;
  logic [IDX_W-1:0] r_last_grant;
  logic             r_neg;
  logic [31:0]      r_mul_a;
  logic [31:0]      r_mul_b;
  logic [63:0]      r_rsp_p;

  logic             w_any;
  logic             w_found;
  logic [IDX_W-1:0] w_cand;
  logic [IDX_W-1:0] w_win;

  logic [31:0]      w_a_arr [NUM_REQ];
  logic [31:0]      w_b_arr [NUM_REQ];
  logic [31:0]      w_sel_a;
  logic [31:0]      w_sel_b;
  logic             w_sel_sgn;
  logic [31:0]      w_mag_a;
  logic [31:0]      w_mag_b;
  logic             w_neg;
  logic [63:0]      w_rsp_fix;
  logic             w_grant_now;

  // --------------------------------------------------------------------------
  // Operand unpacking
  // --------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_a_arr[gi] = op_a[32*gi +: 32];
      assign w_b_arr[gi] = op_b[32*gi +: 32];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Round-robin pick: scan last_grant+1, +2, ... with wrap; the previous
  // winner is visited last, so it only wins if nobody else is asking.
  // --------------------------------------------------------------------------
  assign w_any = |req;

  always_comb begin
    w_found = 1'b0;
    w_win   = r_last_grant;
    w_cand  = r_last_grant;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = IDX_W'((32'(r_last_grant) + 32'(k)) % NUM_REQ);
      if (!w_found && req[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Magnitude conversion of the winner's operands. Negating 32'h8000_0000
  // wraps back to itself, which is exactly the unsigned magnitude 2^31.
  // --------------------------------------------------------------------------
  assign w_sel_a   = w_a_arr[w_win];
  assign w_sel_b   = w_b_arr[w_win];
  assign w_sel_sgn = req_signed[w_win];

  assign w_mag_a = (w_sel_sgn && w_sel_a[31]) ? (~w_sel_a + 32'd1) : w_sel_a;
  assign w_mag_b = (w_sel_sgn && w_sel_b[31]) ? (~w_sel_b + 32'd1) : w_sel_b;
  assign w_neg   = w_sel_sgn & (w_sel_a[31] ^ w_sel_b[31]);

  assign w_rsp_fix   = r_neg ? (~mul_p + 64'd1) : mul_p;
  assign w_grant_now = (r_state == c_IDLE) && w_any;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic. mul_dne is not looked at in START because the
  // multiplier still shows the previous operation's done flag there.
  // --------------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE:  if (w_any) w_next = c_START;
      c_START: w_next = c_BUSY;
      c_BUSY:  if (mul_dne) w_next = c_DONE;
      c_DONE:  w_next = c_IDLE;
      default: w_next = c_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    ack     = '0;
    busy    = (r_state != c_IDLE);
    mul_ena = (r_state == c_START) || (r_state == c_BUSY);
    mul_rst = (r_state == c_START);
    if (r_state == c_DONE) begin
      ack[r_grant] = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath registers. Operands are captured only in the grant cycle so
  // requester-side changes cannot disturb the operation in flight; the
  // product register holds until the next completion.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant      <= '0;
      r_last_grant <= c_LAST_RST;
      r_neg        <= 1'b0;
      r_mul_a      <= '0;
      r_mul_b      <= '0;
      r_rsp_p      <= '0;
    end else begin
      if (w_grant_now) begin
        r_grant <= w_win;
        r_mul_a <= w_mag_a;
        r_mul_b <= w_mag_b;
        r_neg   <= w_neg;
      end
      if ((r_state == c_BUSY) && mul_dne) begin
        r_rsp_p <= w_rsp_fix;
      end
      if (r_state == c_DONE) begin
        r_last_grant <= r_grant;
      end
    end
  end

  assign rsp_p = r_rsp_p;
  assign mul_a = r_mul_a;
  assign mul_b = r_mul_b;

endmodule
`default_nettype wire

// File: doc/mult_arbiter.md
# mult_arbiter

Round-robin arbiter and sequencer that shares one iterative 32x32 shift-add multiplier among NUM_REQ requesters. It latches the granted requester's operands, converts signed operands to magnitudes, and drives the multiplier's enable/load strobes. It waits for the multiplier's done flag, applies the sign correction, and returns the 64-bit product to the granted requester with a one-cycle acknowledge. It sits between the execute-stage requesters and the single multiplier instance.

## Interface
- NUM_REQ, 4, number of requesters (2..8).
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  level request per requester; held until ack.
- req_signed  in  NUM_REQ  1 = operands are two's-complement, 0 = unsigned.
- op_a  in  32*NUM_REQ  operand A, requester i at bits [32i+31:32i].
- op_b  in  32*NUM_REQ  operand B, same packing.
- ack  out  NUM_REQ  one-hot, one-cycle pulse: rsp_p valid for that requester.
- rsp_p  out  64  product, shared by all requesters.
- busy  out  1  high in every state except IDLE.
- mul_a  out  32  multiplier operand A (magnitude).
- mul_b  out  32  multiplier operand B (magnitude).
- mul_ena  out  1  multiplier enable.
- mul_rst  out  1  multiplier load strobe (its rst pin).
- mul_p  in  64  multiplier product.
- mul_dne  in  1  multiplier done flag.

## Operation
- States: IDLE, START, BUSY, DONE.
- IDLE: if any req bit is high, select winner i by round-robin, searching from last_grant+1 upward with wrap. Latch i, mul_a/mul_b, and neg = req_signed[i] & (a[31]^b[31]). Go to START. With no request, stay in IDLE.
- Magnitude: signed operand with bit31 set -> two's-complement negate; 32'h8000_0000 -> 32'h8000_0000 (unsigned 2^31). Unsigned operands pass unchanged.
- START (1 cycle): mul_ena=1, mul_rst=1. Go to BUSY. mul_dne is ignored here because it still holds the previous operation's value.
- BUSY: mul_ena=1, mul_rst=0. When mul_dne is sampled high, register rsp_p = neg ? -mul_p (64-bit two's complement) : mul_p. Then go to DONE.
- DONE (1 cycle): ack[i]=1, mul_ena=0, last_grant=i, go to IDLE.
- rsp_p holds its value until the next DONE capture.
- mul_a/mul_b hold their values from latch until the next grant.
- Operands and req_signed are sampled only in the IDLE grant cycle. Later changes have no effect on the operation in flight.
- A requester must drop req in the cycle after its ack. If req is still high in IDLE, it is a new request, and it is lowest priority because last_grant = i.
- The arbiter does not correct datapath accuracy; rsp_p is mul_p with sign correction only.

## Timing
- Reset values: state=IDLE, ack=0, rsp_p=0, busy=0, mul_a=0, mul_b=0, mul_ena=0, mul_rst=0, last_grant=NUM_REQ-1, so requester 0 has first priority.
- Cycle numbering: cycle 0 is the IDLE cycle in which req is sampled. START is cycle 1 and BUSY starts at cycle 2.
- Latency to ack with |a|==0 or |b|==0: ack in cycle 4.
- Otherwise ack in cycle h+5, where h is the index of the highest set bit of |a|. BUSY lasts at most 34 cycles.
- Back-to-back: the next grant is evaluated in the first IDLE cycle after DONE. The minimum request-to-request spacing is 5 cycles.
- busy is high from cycle 1 through DONE inclusive.
- Reset mid-operation (any state) takes effect at the next edge:
  - return to IDLE; ack, busy, mul_ena and mul_rst drop to 0;
  - the in-flight result is discarded and no ack is issued;
  - the multiplier is left as-is, because every new operation reloads it via START.
- Simultaneous rst and req: rst wins and no grant is made.
- Simultaneous requests are resolved by round-robin only; no requester waits more than NUM_REQ-1 other operations.

## Test plan
- Reset, then req[0] with a=0, b=5, unsigned -> ack[0] in cycle 4, rsp_p=0, mul_rst high only in cycle 1.
- req[1] with a=3, b=7, unsigned -> ack[1] in cycle 6, rsp_p=21, busy high cycles 1..6.
- req[2] with signed a=-6 (32'hFFFF_FFFA), b=7 -> mul_a=6, rsp_p=64'hFFFF_FFFF_FFFF_FFD6 (-42). Signed -6 x -7 -> rsp_p=42.
- All four req held high from reset, each dropping req after its ack -> ack order 0,1,2,3. Re-raising req[0] while req[3] is pending -> 3 is served before 0.
- Change op_a of the granted requester during BUSY -> result reflects the operand sampled at grant. Assert rst in BUSY -> no ack, IDLE next cycle, next request completes correctly.
- Signed 32'h8000_0000 x 1 -> mul_a=32'h8000_0000, rsp_p=64'hFFFF_FFFF_8000_0000.
